somador_serial8b: RTL
=====================

SOMADOR_SERIAL8B -- requirements
Module: somador_serial8b

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk.
REQ-002 clk  input  1  system clock; all registers update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin one 8-bit addition; sampled only in IDLE.
REQ-005 a  input  8  augend, captured on accepted start.
REQ-006 b  input  8  addend, captured on accepted start.
REQ-007 cin  input  1  carry-in, captured on accepted start.
REQ-008 s  output  8  registered sum (a + b + cin) mod 256.
REQ-009 cout  output  1  registered carry-out of bit 7.
REQ-010 ovf  output  1  registered two's-complement overflow: carry into bit 7 XOR carry out of bit 7.
REQ-011 busy  output  1  high while an addition is in progress.
REQ-012 done  output  1  single-cycle pulse marking s/cout/ovf valid.

Function
REQ-013 The block SHALL compute the sum bit-serially with one full-adder cell reused over 8 cycles, LSB first.
REQ-014 FSM states SHALL be IDLE, SOMA and FIM.
REQ-015 IDLE with start=1 SHALL latch a, b and cin into internal registers, clear the bit counter to 0, and go to SOMA; IDLE with start=0 SHALL stay in IDLE.
REQ-016 Each cycle in SOMA SHALL process bit i = counter: shift result bit a[i]^b[i]^c into the sum register, update c = majority(a[i], b[i], c), and increment counter.
REQ-017 When counter=7 is processed, SOMA SHALL go to FIM; counter SHALL be 3 bits and wraps to 0 unused.
REQ-018 In FIM the block SHALL drive done=1 for exactly one cycle, present the final s/cout/ovf, and return to IDLE.
REQ-019 Latency: start sampled at edge N -> SOMA during edges N+1..N+8 -> done=1 in the cycle following edge N+9; 10 cycles total from start to done.
REQ-020 busy SHALL be 1 in SOMA and FIM, and 0 in IDLE.
REQ-021 start while busy=1 SHALL be ignored, and a/b/cin changes while busy SHALL NOT affect the result.
REQ-022 start held high continuously SHALL begin a new operation on the first IDLE cycle after FIM, giving back-to-back operations every 10 cycles.
REQ-023 s, cout and ovf SHALL hold the last completed result until the next FIM; during SOMA they SHALL keep the previous result (the partial sum stays internal).
REQ-024 Arithmetic: {cout,s} SHALL equal a + b + cin exactly (9-bit result); ovf SHALL equal (a[7]==b[7]) && (s[7]!=a[7]).

Reset
REQ-025 rst=1 SHALL force IDLE, counter=0, internal carry=0, s=8'h00, cout=0, ovf=0, busy=0 and done=0 on the next edge.
REQ-026 rst asserted mid-operation (SOMA or FIM) SHALL abort without a done pulse; the first start accepted after rst is released SHALL complete normally.
REQ-027 rst has priority over start in the same cycle.

Verification
REQ-028 a=8'h0F, b=8'h01, cin=0, start pulse -> after 10 cycles done=1, s=8'h10, cout=0, ovf=0.
REQ-029 a=8'hFF, b=8'h01, cin=0 -> s=8'h00, cout=1, ovf=0; then a=8'hFF, b=8'hFF, cin=1 -> s=8'hFF, cout=1, ovf=0.
REQ-030 a=8'h7F, b=8'h01, cin=0 -> s=8'h80, cout=0, ovf=1; a=8'h80, b=8'h80 -> s=8'h00, cout=1, ovf=1.
REQ-031 Start a=8'h12, b=8'h34; at cycle 3 pulse start with a=8'hFF, b=8'hFF -> single done, s=8'h46; busy stays 1 across cycles 1-9.
REQ-032 Start an operation, assert rst at cycle 5 -> no done pulse, all outputs 0; then a=8'h01, b=8'h02 -> s=8'h03, done after 10 cycles.
REQ-033 start held high with constant a=8'h55, b=8'hAA, cin=1 -> done every 10 cycles, s=8'h00, cout=1; random self-check of 1000 operations against a+b+cin.

Source files
------------

// File: rtl/somador_serial8b_if.sv
// somador_serial8b_if: operand/result bundle for the bit-serial 8-bit adder
interface somador_serial8b_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] s;
  logic       cout;
  logic       ovf;
  logic       busy;
  logic       done;
  modport master (output start, a, b, cin, input s, cout, ovf, busy, done);
  modport slave  (input start, a, b, cin, output s, cout, ovf, busy, done);
endinterface

// File: rtl/somador_serial8b.sv
// somador_serial8b: 8-bit adder built from one full-adder cell reused LSB first over 8 cycles
module somador_serial8b (
  input  logic                  clk,
  input  logic                  rst,
  somador_serial8b_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, SOMA, FIM} state_t;
  state_t state, next_state;
  logic [7:0] ra, rb, sum, s_q;
  logic [2:0] cnt;
  logic c, cout_q, ovf_q, done_q, load, step, fin, bit_a, bit_b;
  always_ff @(posedge clk)
    state <= rst ? IDLE : next_state;
  always_comb
    next_state = state == IDLE ? (bus.start ? SOMA : IDLE) :
                 state == SOMA ? (cnt == 3'd7 ? FIM : SOMA) : IDLE;
  always_comb begin
    load = state == IDLE && bus.start;
    step = state == SOMA;
    fin  = state == FIM;
  end
  assign bit_a = ra[cnt];
  assign bit_b = rb[cnt];
  // results only move to the outputs on FIM, so the partial sum never leaks
  always_ff @(posedge clk) begin
    if (rst) begin
      ra     <= '0;
      rb     <= '0;
      sum    <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (load) begin
        ra  <= bus.a;
        rb  <= bus.b;
        c   <= bus.cin;
        cnt <= '0;
      end
      if (step) begin
        sum <= {bit_a ^ bit_b ^ c, sum[7:1]};
        c   <= (bit_a & bit_b) | (bit_a & c) | (bit_b & c);
        cnt <= cnt + 3'd1;
      end
      if (fin) begin
        s_q    <= sum;
        cout_q <= c;
        ovf_q  <= (ra[7] == rb[7]) && (sum[7] != ra[7]);
      end
    end
  end
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.done = done_q;
  assign bus.busy = state != IDLE;
endmodule
